smart_alarm_ctrl: RTL
=====================

SMART_ALARM_CTRL -- requirements
Module: smart_alarm_ctrl

Interface
REQ-001 SHALL have parameter N_SENSORS, default 4, number of sensor channels (2..8).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 4, consecutive stable cycles needed to accept a sensor change (1..255).
REQ-003 SHALL have parameter EXIT_DELAY, default 8, cycles from arm to ARMED (1..65535).
REQ-004 SHALL have parameter ENTRY_DELAY, default 16, cycles from entry trip to ALARM (1..65535).
REQ-005 SHALL have parameters MOTION_MASK, ENTRY_MASK, INSTANT_MASK (N_SENSORS bits each), defaults 4'b0001, 4'b1010, 4'b0100, giving channel classes; the masks shall not overlap.
REQ-006 clk  input  1  sole clock, rising edge.
REQ-007 rst  input  1  reset; synchronous and active-high.
REQ-008 sensor_in  input  N_SENSORS  raw sensor levels, asynchronous to clk, high = active.
REQ-009 arm  input  1  single-cycle arm request.
REQ-010 disarm  input  1  single-cycle disarm request.
REQ-011 alarm  output  1  siren drive, registered.
REQ-012 armed  output  1  high in EXIT, ARMED, ENTRY, ALARM.
REQ-013 state  output  3  current FSM state encoding.
REQ-014 trip_latch  output  N_SENSORS  sticky record of channels that were active while ARMED or ENTRY.

Function
REQ-015 Each raw input SHALL pass a two-flop synchronizer followed by a debouncer; the debounced level shall change only after the synchronized value differs from it for DEBOUNCE_CYCLES consecutive cycles; any agreeing cycle shall clear the run counter.
REQ-016 FSM states SHALL be DISARMED=0, EXIT=1, ARMED=2, ENTRY=3, ALARM=4; all transitions take effect on the next clock edge.
REQ-017 DISARMED + arm -> EXIT, countdown loaded with EXIT_DELAY-1; sensors ignored in EXIT.
REQ-018 EXIT with countdown 0 -> ARMED; otherwise decrement.
REQ-019 ARMED: any debounced INSTANT channel, or any MOTION channel AND any ENTRY channel in the same cycle -> ALARM; else any ENTRY channel -> ENTRY with countdown loaded ENTRY_DELAY-1; instant/coincidence takes priority over entry.
REQ-020 ENTRY: instant or coincidence condition -> ALARM immediately; countdown 0 -> ALARM; otherwise decrement; further entry trips do not reload.
REQ-021 ALARM: held until disarm (or timeout, REQ-029); alarm output = 1 exactly while state is ALARM, registered.
REQ-022 disarm in any state -> DISARMED, clears countdown and trip_latch; disarm and arm in the same cycle: disarm wins; arm outside DISARMED is ignored.
REQ-023 trip_latch[i] SHALL set in the cycle after debounced channel i is high while state is ARMED or ENTRY, and clear only on disarm or rst.
REQ-024 Countdown SHALL be 16 bits, never wraps below 0.

Reset
REQ-025 On rst: state=DISARMED, alarm=0, armed=0, trip_latch=0, countdown=0, synchronizers, debounced levels and run counters = 0.
REQ-026 rst mid-ENTRY or mid-ALARM SHALL return to DISARMED in the next cycle with no alarm pulse.
REQ-027 rst SHALL dominate arm and disarm.

Configuration
REQ-028 Macro ALARM_SIREN_TIMEOUT_EN SHALL select the siren timeout feature; SIREN_CYCLES parameter, default 64, present only when defined.
REQ-029 With ALARM_SIREN_TIMEOUT_EN defined: ALARM lasting SIREN_CYCLES cycles -> ARMED, trip_latch retained; without it: ALARM held until disarm or rst.

Structure
REQ-030 Package alarm_pkg SHALL hold the state enum/encoding, countdown width constant and the default mask constants.
REQ-031 Sub-module sensor_debounce (synchronizer + run counter, one channel) SHALL be instantiated N_SENSORS times via generate.

Verification (defaults N=4, DEBOUNCE=4, EXIT=8, ENTRY=16)
REQ-032 Glitch: sensor_in[2] high 3 cycles while ARMED -> no debounced change, alarm stays 0, trip_latch=0.
REQ-033 Instant: ARMED, sensor_in[2] high held -> ALARM 2+4 cycles later, alarm=1, trip_latch=4'b0100.
REQ-034 Entry: ARMED, sensor_in[1] high; disarm 10 cycles after ENTRY entered -> DISARMED, alarm never 1; no disarm -> alarm=1 exactly 16 cycles after ENTRY entered.
REQ-035 Coincidence: ARMED, sensor_in[0] and sensor_in[3] high same cycle -> ALARM directly, ENTRY skipped, trip_latch=4'b1001.
REQ-036 Arm+disarm same cycle in DISARMED -> stays DISARMED; arm then sensor_in[1] during EXIT -> ARMED after 8 cycles, trip_latch=0.
REQ-037 rst during ALARM -> next cycle state=0, alarm=0; with ALARM_SIREN_TIMEOUT_EN, ALARM with no disarm -> ARMED after 64 cycles.

Source files
------------

// File: rtl/alarm_pkg.sv
// alarm_pkg: state encoding, countdown width and default channel masks
// shared by the smart alarm controller and its debounce front end.
package alarm_pkg;

    typedef enum logic [2:0] {
        ST_DISARMED = 3'd0,
        ST_EXIT     = 3'd1,
        ST_ARMED    = 3'd2,
        ST_ENTRY    = 3'd3,
        ST_ALARM    = 3'd4
    } alarm_state_e;

    localparam int CNT_W = 16;

    localparam logic [3:0] DEF_MOTION_MASK  = 4'b0001;
    localparam logic [3:0] DEF_ENTRY_MASK   = 4'b1010;
    localparam logic [3:0] DEF_INSTANT_MASK = 4'b0100;

    // Countdown step that holds at zero instead of wrapping.
    function automatic logic [CNT_W-1:0] cnt_dec(
        input logic [CNT_W-1:0] c
    );
        return (c == '0) ? '0 : c - CNT_W'(1);
    endfunction

endpackage

// File: rtl/sensor_debounce.sv
// sensor_debounce: two-flop synchronizer plus run-length debouncer for
// one asynchronous sensor line; level changes after a full disagreeing run.
module sensor_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_in,
    output logic level_out
);

    localparam logic [7:0] RUN_LAST = 8'(DEBOUNCE_CYCLES - 1);

    logic       s1_q, s1_d;
    logic       s2_q, s2_d;
    logic       level_q, level_d;
    logic [7:0] run_q, run_d;

    // Next-state: shift the synchronizer, count disagreeing cycles.
    always_comb begin
        s1_d    = raw_in;
        s2_d    = s1_q;
        level_d = level_q;
        run_d   = '0;
        if (s2_q != level_q) begin
            if (run_q == RUN_LAST) begin
                level_d = s2_q;
                run_d   = '0;
            end else begin
                run_d = run_q + 8'd1;
            end
        end
    end

    // Registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            level_q <= 1'b0;
            run_q   <= '0;
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            level_q <= level_d;
            run_q   <= run_d;
        end
    end

    assign level_out = level_q;

endmodule

// File: rtl/smart_alarm_ctrl.sv
// smart_alarm_ctrl: arm/exit/entry/alarm sequencer over debounced sensors.
// Optional siren timeout is enabled by defining ALARM_SIREN_TIMEOUT_EN.
module smart_alarm_ctrl
    import alarm_pkg::*;
#(
`ifdef ALARM_SIREN_TIMEOUT_EN
    parameter int SIREN_CYCLES = 64,
`endif
    parameter int N_SENSORS       = 4,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int EXIT_DELAY      = 8,
    parameter int ENTRY_DELAY     = 16,
    parameter logic [N_SENSORS-1:0] MOTION_MASK  =
        N_SENSORS'(DEF_MOTION_MASK),
    parameter logic [N_SENSORS-1:0] ENTRY_MASK   =
        N_SENSORS'(DEF_ENTRY_MASK),
    parameter logic [N_SENSORS-1:0] INSTANT_MASK =
        N_SENSORS'(DEF_INSTANT_MASK)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_SENSORS-1:0] sensor_in,
    input  logic                 arm,
    input  logic                 disarm,
    output logic                 alarm,
    output logic                 armed,
    output logic [2:0]           state,
    output logic [N_SENSORS-1:0] trip_latch
);

    localparam logic [CNT_W-1:0] EXIT_LOAD  = CNT_W'(EXIT_DELAY - 1);
    localparam logic [CNT_W-1:0] ENTRY_LOAD = CNT_W'(ENTRY_DELAY - 1);
`ifdef ALARM_SIREN_TIMEOUT_EN
    localparam logic [CNT_W-1:0] SIREN_LOAD = CNT_W'(SIREN_CYCLES - 1);
`else
    localparam logic [CNT_W-1:0] SIREN_LOAD = '0;
`endif

    logic [N_SENSORS-1:0] deb;

    alarm_state_e         state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [N_SENSORS-1:0] trip_q, trip_d;
    logic                 alarm_q, alarm_d;
    logic                 armed_q, armed_d;

    logic hit_instant;
    logic hit_coinc;
    logic hit_entry;

    for (genvar g = 0; g < N_SENSORS; g++) begin : g_deb
        sensor_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk      (clk),
            .rst      (rst),
            .raw_in   (sensor_in[g]),
            .level_out(deb[g])
        );
    end

    // Classify the debounced channels into trip conditions.
    always_comb begin
        hit_instant = |(deb & INSTANT_MASK);
        hit_coinc   = (|(deb & MOTION_MASK)) & (|(deb & ENTRY_MASK));
        hit_entry   = |(deb & ENTRY_MASK);
    end

    // Next-state, countdown and trip record; disarm overrides all.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        trip_d  = trip_q;
        if (disarm) begin
            state_d = ST_DISARMED;
            cnt_d   = '0;
            trip_d  = '0;
        end else begin
            unique case (state_q)
                ST_DISARMED: begin
                    if (arm) begin
                        state_d = ST_EXIT;
                        cnt_d   = EXIT_LOAD;
                    end
                end
                ST_EXIT: begin
                    if (cnt_q == '0) begin
                        state_d = ST_ARMED;
                    end else begin
                        cnt_d = cnt_dec(cnt_q);
                    end
                end
                ST_ARMED: begin
                    trip_d = trip_q | deb;
                    if (hit_instant || hit_coinc) begin
                        state_d = ST_ALARM;
                        cnt_d   = SIREN_LOAD;
                    end else if (hit_entry) begin
                        state_d = ST_ENTRY;
                        cnt_d   = ENTRY_LOAD;
                    end
                end
                ST_ENTRY: begin
                    trip_d = trip_q | deb;
                    if (hit_instant || hit_coinc || cnt_q == '0) begin
                        state_d = ST_ALARM;
                        cnt_d   = SIREN_LOAD;
                    end else begin
                        cnt_d = cnt_dec(cnt_q);
                    end
                end
                ST_ALARM: begin
`ifdef ALARM_SIREN_TIMEOUT_EN
                    if (cnt_q == '0) begin
                        state_d = ST_ARMED;
                    end else begin
                        cnt_d = cnt_dec(cnt_q);
                    end
`endif
                end
                default: begin
                    state_d = ST_DISARMED;
                    cnt_d   = '0;
                end
            endcase
        end
        alarm_d = (state_d == ST_ALARM);
        armed_d = (state_d != ST_DISARMED);
    end

    // State and registered outputs with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_DISARMED;
            cnt_q   <= '0;
            trip_q  <= '0;
            alarm_q <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            trip_q  <= trip_d;
            alarm_q <= alarm_d;
            armed_q <= armed_d;
        end
    end

    assign alarm      = alarm_q;
    assign armed      = armed_q;
    assign state      = state_q;
    assign trip_latch = trip_q;

endmodule
